// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NumReq producers.
module fifo_write_arbiter #(
  parameter int DataSize = 3,
  parameter int NumReq   = 4,
  parameter int MaxBurst = 4
) (
  input  logic                         Wclk,
  input  logic                         Wreset,
  input  logic                         Enable,
  input  logic [NumReq-1:0]            ReqValid,
  input  logic [NumReq*DataSize-1:0]   ReqData,
  input  logic [NumReq-1:0]            ReqLast,
  output logic [NumReq-1:0]            ReqReady,
  input  logic                         full,
  output logic                         Push,
  output logic [DataSize-1:0]          DataIn,
  output logic [$clog2(NumReq)-1:0]    GrantId,
  output logic                         Busy
);
  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d, ptr_q, ptr_d, pick;
  logic [CntW-1:0] cnt_q, cnt_d;
  int              j;
  always_ff @(posedge Wclk or posedge Wreset) begin
    if (Wreset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    pick     = ptr_q;
    j        = 0;
    ReqReady = '0;
    Push     = 1'b0;
    DataIn   = '0;
    // scan from the far end so the index closest to the pointer wins
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      j = (j >= NumReq) ? j - NumReq : j;
      if (ReqValid[j]) pick = IdW'(j);
    end
    if (state_q == IDLE) begin
      if (Enable && |ReqValid) begin
        grant_d = pick;
        cnt_d   = '0;
        state_d = BURST;
      end
    end else begin
      ReqReady[grant_q] = ~full;
      Push              = ReqValid[grant_q] & ~full;
      DataIn            = ReqData[grant_q*DataSize +: DataSize];
      if (Push) begin
        cnt_d = cnt_q + 1'b1;
        if (ReqLast[grant_q] || cnt_d == CntW'(MaxBurst)) begin
          state_d = IDLE;
          ptr_d   = (grant_q == IdW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
        end
      end
    end
  end
  assign GrantId = grant_q;
  assign Busy    = (state_q == BURST);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed self-checking bench for the round-robin FIFO write arbiter.
module tb_fifo_write_arbiter;
  logic        Wclk = 0, Wreset = 1, Enable = 0, full = 0;
  logic [3:0]  ReqValid = '0, ReqLast = '0, ReqReady;
  logic [11:0] ReqData = '0;
  logic        Push, Busy;
  logic [2:0]  DataIn;
  logic [1:0]  GrantId;
  int          n_tests = 0, n_fail = 0, pushes;

  fifo_write_arbiter #(.DataSize(3), .NumReq(4), .MaxBurst(4)) dut (
    .Wclk(Wclk), .Wreset(Wreset), .Enable(Enable), .ReqValid(ReqValid),
    .ReqData(ReqData), .ReqLast(ReqLast), .ReqReady(ReqReady), .full(full),
    .Push(Push), .DataIn(DataIn), .GrantId(GrantId), .Busy(Busy)
  );

  always #5 Wclk = ~Wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Wclk);
    #1;
  endtask

  task automatic do_reset();
    Wreset = 1; Enable = 0; full = 0; ReqValid = '0; ReqLast = '0;
    @(negedge Wclk);
    cyc();
    Wreset = 0;
  endtask

  always @(negedge Wclk) check("push_while_full", {31'b0, Push & full}, 0);

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) ReqData[i*3 +: 3] = 3'(i + 1);
    // reset state
    @(negedge Wclk);
    check("rst_busy", Busy, 0); check("rst_push", Push, 0);
    check("rst_ready", ReqReady, 0); check("rst_grant", GrantId, 0); check("rst_data", DataIn, 0);
    cyc(); Wreset = 0;

    // 1: single-beat burst from requester 0
    ReqData[2:0] = 3'd5; Enable = 1; ReqValid = 4'b0001; ReqLast = 4'b0001;
    @(negedge Wclk); check("t1_arb_busy", Busy, 0); check("t1_arb_push", Push, 0);
    cyc(); @(negedge Wclk);
    check("t1_busy", Busy, 1); check("t1_grant", GrantId, 0); check("t1_push", Push, 1);
    check("t1_data", DataIn, 5); check("t1_ready", ReqReady, 4'b0001);
    cyc(); ReqValid = 4'b0000; @(negedge Wclk);
    check("t1_idle", Busy, 0); check("t1_hold_grant", GrantId, 0);
    cyc(); ReqValid = 4'b0011; ReqLast = 4'b0000; @(negedge Wclk);
    cyc(); @(negedge Wclk);
    check("t1_ptr_grant", GrantId, 1); check("t1_ptr_busy", Busy, 1);
    ReqData[2:0] = 3'd1;

    // 2: fairness, all continuously valid, 4-beat bursts plus one bubble
    do_reset();
    Enable = 1; ReqValid = 4'b1111;
    @(negedge Wclk); check("t2_c0_push", Push, 0);
    for (int c = 1; c <= 20; c++) begin
      cyc(); @(negedge Wclk);
      check($sformatf("t2_c%0d_push", c), Push, (c % 5) != 0);
      check($sformatf("t2_c%0d_busy", c), Busy, (c % 5) != 0);
      check($sformatf("t2_c%0d_grant", c), GrantId, ((c - 1) / 5) % 4);
      if (c % 5 != 0) check($sformatf("t2_c%0d_data", c), DataIn, ((c - 1) / 5) % 4 + 1);
    end

    // 3: full stalls requester 2 after beat 2
    do_reset();
    Enable = 1; ReqValid = 4'b0100; pushes = 0;
    @(negedge Wclk); check("t3_arb_push", Push, 0);
    for (int s = 1; s <= 8; s++) begin
      cyc(); full = (s >= 3 && s <= 5); @(negedge Wclk);
      pushes += int'(Push);
      if (s <= 7) check($sformatf("t3_s%0d_busy", s), Busy, 1);
      if (s <= 7) check($sformatf("t3_s%0d_grant", s), GrantId, 2);
      check($sformatf("t3_s%0d_push", s), Push, s inside {1, 2, 6, 7});
      check($sformatf("t3_s%0d_ready", s), ReqReady, (s inside {1, 2, 6, 7}) ? 4'b0100 : 4'b0000);
    end
    check("t3_total_pushes", pushes, 4);
    check("t3_end_busy", Busy, 0);

    // 4: owner 1 stalls on its own valid while requester 3 waits
    do_reset();
    Enable = 1; ReqValid = 4'b1010;
    @(negedge Wclk);
    for (int s = 1; s <= 8; s++) begin
      cyc(); ReqValid = (s == 3 || s == 4) ? 4'b1000 : 4'b1010; @(negedge Wclk);
      check($sformatf("t4_s%0d_grant", s), GrantId, (s == 8) ? 3 : 1);
      check($sformatf("t4_s%0d_busy", s), Busy, s != 7);
      check($sformatf("t4_s%0d_push", s), Push, s inside {1, 2, 5, 6, 8});
      check($sformatf("t4_s%0d_r3", s), ReqReady[3], s == 8);
    end

    // 5: Enable gates new grants only
    do_reset();
    Enable = 1; ReqValid = 4'b0001; ReqLast = 4'b0001;
    @(negedge Wclk);
    cyc(); @(negedge Wclk); check("t5_first_push", Push, 1);
    cyc(); Enable = 0; ReqValid = 4'b1111; ReqLast = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      @(negedge Wclk);
      check($sformatf("t5_dis%0d_busy", s), Busy, 0); check($sformatf("t5_dis%0d_push", s), Push, 0);
      cyc();
    end
    Enable = 1; @(negedge Wclk); check("t5_arb_busy", Busy, 0);
    cyc(); Enable = 0; pushes = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge Wclk);
      pushes += int'(Push);
      if (s < 4) check($sformatf("t5_b%0d_grant", s), GrantId, 1);
      if (s == 0) check("t5_b0_data", DataIn, 2);
      check($sformatf("t5_b%0d_busy", s), Busy, s < 4);
      cyc();
    end
    check("t5_pushes", pushes, 4);

    // 6: reset mid-burst from requester 3
    do_reset();
    Enable = 1; ReqValid = 4'b1000;
    @(negedge Wclk);
    cyc(); @(negedge Wclk); check("t6_grant3", GrantId, 3);
    cyc(); @(negedge Wclk); check("t6_beat2_push", Push, 1);
    #1 Wreset = 1;
    #1;
    check("t6_rst_push", Push, 0); check("t6_rst_busy", Busy, 0);
    check("t6_rst_ready", ReqReady, 0); check("t6_rst_grant", GrantId, 0);
    cyc(); Wreset = 0; ReqValid = 4'b1111;
    @(negedge Wclk); check("t6_arb_busy", Busy, 0);
    cyc(); @(negedge Wclk);
    check("t6_regrant", GrantId, 0); check("t6_regrant_busy", Busy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
